// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: IF/ID FSM encoding, NOP encoding and the
// register-field positions used by hazard and forwarding logic.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } if_id_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

endpackage

// File: rtl/load_use_detect.sv
// Purely combinational load-use compare between the EX-stage load target
// and the source registers of the instruction sitting in ID.
module load_use_detect (
  input  logic       valid,
  input  logic       mem_read,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  output logic       hazard
);

  // $0 is never a real dependency, and a squashed slot reads nothing.
  assign hazard = valid && mem_read && (rt_ex != 5'd0) &&
                  ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use stall and branch/jump flush control.
// Optional IF_ID_PERF_CNT_EN adds StallCount/FlushCount performance counters.
module if_id_hazard_stage
  import pipe_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_DEPTH       = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction_in,
  input  logic [31:0] PCAdder_in,
  input  logic        MemRead_EX,
  input  logic [4:0]  AddressRt_EX,
  input  logic        Flush_in,
  output logic [31:0] Instruction_out,
  output logic [31:0] PCAdder_out,
  output logic        Valid_out,
  output logic        PCWrite,
  output logic        Bubble
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);

  if_id_state_t state_q, state_d;
  logic [2:0]   stall_cnt_q, stall_cnt_d;
  logic [1:0]   flush_cnt_q, flush_cnt_d;
  logic         hazard;
  logic         do_load;
  logic         do_nop;

  load_use_detect u_load_use_detect (
    .valid    (Valid_out),
    .mem_read (MemRead_EX),
    .rt_ex    (AddressRt_EX),
    .rs_id    (Instruction_out[RS_MSB:RS_LSB]),
    .rt_id    (Instruction_out[RT_MSB:RT_LSB]),
    .hazard   (hazard)
  );

  // Flush outranks everything, including a stall already in progress.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    PCWrite     = 1'b1;
    Bubble      = 1'b0;
    do_load     = 1'b0;
    do_nop      = 1'b0;

    if (Flush_in) begin
      do_nop      = 1'b1;
      Bubble      = 1'b1;
      stall_cnt_d = 3'd0;
      if (FLUSH_DEPTH > 1) begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_RELOAD;
      end else begin
        state_d     = RUN;
        flush_cnt_d = 2'd0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            PCWrite = 1'b0;
            Bubble  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d     = STALL;
              stall_cnt_d = STALL_RELOAD;
            end
          end else begin
            do_load = 1'b1;
          end
        end
        STALL: begin
          PCWrite = 1'b0;
          Bubble  = 1'b1;
          if (stall_cnt_q <= 3'd1) begin
            state_d     = RUN;
            stall_cnt_d = 3'd0;
          end else begin
            stall_cnt_d = stall_cnt_q - 3'd1;
          end
        end
        FLUSH: begin
          do_nop = 1'b1;
          if (flush_cnt_q <= 2'd1) begin
            state_d     = RUN;
            flush_cnt_d = 2'd0;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= RUN;
      stall_cnt_q <= 3'd0;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Squashed slots still advance the PC+4 so the register tracks fetch.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Instruction_out <= NOP_INSTR;
      PCAdder_out     <= 32'd0;
      Valid_out       <= 1'b0;
    end else if (do_nop) begin
      Instruction_out <= NOP_INSTR;
      PCAdder_out     <= PCAdder_in;
      Valid_out       <= 1'b0;
    end else if (do_load) begin
      Instruction_out <= Instruction_in;
      PCAdder_out     <= PCAdder_in;
      Valid_out       <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (!PCWrite) StallCount <= StallCount + 32'd1;
      if (Flush_in) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Bench for if_id_hazard_stage: two instances (1/1 and 3/2 parameters) share
// stimulus and are checked against a remaining-cycles model every cycle.
module tb_if_id_hazard_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] Instruction_in = 32'h0;
  logic [31:0] PCAdder_in = 32'h0;
  logic        MemRead_EX = 1'b0;
  logic [4:0]  AddressRt_EX = 5'd0;
  logic        Flush_in = 1'b0;

  logic [31:0] a_instr, a_pc, b_instr, b_pc;
  logic        a_valid, a_pcw, a_bub, b_valid, b_pcw, b_bub;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  int assertions = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  if_id_hazard_stage #(.LOAD_STALL_CYCLES(1), .FLUSH_DEPTH(1)) dut_a (
    .Clk(Clk), .Rst(Rst), .Instruction_in(Instruction_in), .PCAdder_in(PCAdder_in),
    .MemRead_EX(MemRead_EX), .AddressRt_EX(AddressRt_EX), .Flush_in(Flush_in),
    .Instruction_out(a_instr), .PCAdder_out(a_pc), .Valid_out(a_valid),
    .PCWrite(a_pcw), .Bubble(a_bub)
`ifdef IF_ID_PERF_CNT_EN
    , .StallCount(a_stall_cnt), .FlushCount(a_flush_cnt)
`endif
  );

  if_id_hazard_stage #(.LOAD_STALL_CYCLES(3), .FLUSH_DEPTH(2)) dut_b (
    .Clk(Clk), .Rst(Rst), .Instruction_in(Instruction_in), .PCAdder_in(PCAdder_in),
    .MemRead_EX(MemRead_EX), .AddressRt_EX(AddressRt_EX), .Flush_in(Flush_in),
    .Instruction_out(b_instr), .PCAdder_out(b_pc), .Valid_out(b_valid),
    .PCWrite(b_pcw), .Bubble(b_bub)
`ifdef IF_ID_PERF_CNT_EN
    , .StallCount(b_stall_cnt), .FlushCount(b_flush_cnt)
`endif
  );

  // Model: per instance, how many more cycles are frozen or squashed.
  int          lsc [2] = '{1, 3};
  int          fd  [2] = '{1, 2};
  logic [31:0] m_instr [2];
  logic [31:0] m_pc [2];
  logic        m_valid [2];
  int          freeze_left [2];
  int          squash_left [2];
  int          m_stalls [2];
  int          m_flushes [2];

  function automatic logic mHazard(int k);
    logic [31:0] ins;
    ins = m_instr[k];
    return m_valid[k] && MemRead_EX && (AddressRt_EX != 5'd0) &&
           (AddressRt_EX == ins[25:21] || AddressRt_EX == ins[20:16]);
  endfunction

  // Returns {PCWrite, Bubble}.
  function automatic logic [1:0] mCtrl(int k);
    if (Flush_in)               return 2'b11;
    else if (squash_left[k] > 0) return 2'b10;
    else if (freeze_left[k] > 0) return 2'b01;
    else if (mHazard(k))         return 2'b01;
    else                         return 2'b10;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!Rst) begin
        m_instr[k] = 32'h0; m_pc[k] = 32'h0; m_valid[k] = 1'b0;
        freeze_left[k] = 0; squash_left[k] = 0;
        m_stalls[k] = 0; m_flushes[k] = 0;
      end else begin
        logic [1:0] c;
        logic       hz;
        c  = mCtrl(k);
        hz = mHazard(k);
        if (!c[1]) m_stalls[k]++;
        if (Flush_in) m_flushes[k]++;
        if (Flush_in) begin
          m_instr[k] = 32'h0; m_valid[k] = 1'b0; m_pc[k] = PCAdder_in;
          squash_left[k] = fd[k] - 1; freeze_left[k] = 0;
        end else if (squash_left[k] > 0) begin
          m_instr[k] = 32'h0; m_valid[k] = 1'b0; m_pc[k] = PCAdder_in;
          squash_left[k]--;
        end else if (freeze_left[k] > 0) begin
          freeze_left[k]--;
        end else if (hz) begin
          freeze_left[k] = lsc[k] - 1;
        end else begin
          m_instr[k] = Instruction_in; m_valid[k] = 1'b1; m_pc[k] = PCAdder_in;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareDut(input int k, input logic [31:0] io, input logic [31:0] po,
                            input logic v, input logic pw, input logic bb);
    logic [1:0] c;
    c = mCtrl(k);
    checkOutput($sformatf("dut%0d.Instruction_out", k), io, m_instr[k]);
    checkOutput($sformatf("dut%0d.PCAdder_out", k), po, m_pc[k]);
    checkOutput($sformatf("dut%0d.Valid_out", k), {31'd0, v}, {31'd0, m_valid[k]});
    checkOutput($sformatf("dut%0d.PCWrite", k), {31'd0, pw}, {31'd0, c[1]});
    checkOutput($sformatf("dut%0d.Bubble", k), {31'd0, bb}, {31'd0, c[0]});
  endtask

  always @(negedge Clk) begin
    compareDut(0, a_instr, a_pc, a_valid, a_pcw, a_bub);
    compareDut(1, b_instr, b_pc, b_valid, b_pcw, b_bub);
`ifdef IF_ID_PERF_CNT_EN
    checkOutput("dut0.StallCount", a_stall_cnt, 32'(m_stalls[0]));
    checkOutput("dut0.FlushCount", a_flush_cnt, 32'(m_flushes[0]));
    checkOutput("dut1.StallCount", b_stall_cnt, 32'(m_stalls[1]));
    checkOutput("dut1.FlushCount", b_flush_cnt, 32'(m_flushes[1]));
`endif
  end

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                               input logic mr, input logic [4:0] rt, input logic fl);
    @(posedge Clk);
    #1;
    Instruction_in = ins; PCAdder_in = pc;
    MemRead_EX = mr; AddressRt_EX = rt; Flush_in = fl;
    @(negedge Clk);
    #1;
  endtask

  localparam logic [31:0] I1  = 32'h01285020; // add $10,$9,$8
  localparam logic [31:0] I2  = 32'h8C0A0008;
  localparam logic [31:0] I3  = 32'h01495820;
  localparam logic [31:0] I4  = 32'h00084020; // rs = $0
  localparam logic [31:0] I5  = 32'h012A4020;
  localparam logic [31:0] I6  = 32'h8C0D0000;
  localparam logic [31:0] I7  = 32'h014B6020; // rs=$10 rt=$11
  localparam logic [31:0] I8  = 32'h016C6820;
  localparam logic [31:0] I10 = 32'h01AE7820;
  localparam logic [31:0] LW  = 32'h8C090004;

  initial begin
    #3;
    checkOutput("reset Instruction_out", a_instr, 32'h0);
    checkOutput("reset Valid_out", {31'd0, a_valid}, 32'd0);
    checkOutput("reset PCWrite", {31'd0, a_pcw}, 32'd1);
    checkOutput("reset Bubble", {31'd0, a_bub}, 32'd0);
    #9 Rst = 1'b1;

    applyStimulus(I1, 32'd4, 1'b0, 5'd0, 1'b0);   // step 0
    checkOutput("s0 a.PCWrite", {31'd0, a_pcw}, 32'd1);
    applyStimulus(I2, 32'd8, 1'b1, 5'd9, 1'b0);   // step 1: rs match
    checkOutput("s1 a.PCWrite", {31'd0, a_pcw}, 32'd0);
    checkOutput("s1 a.Bubble", {31'd0, a_bub}, 32'd1);
    checkOutput("s1 a.Instruction_out", a_instr, I1);
    applyStimulus(I2, 32'd8, 1'b0, 5'd0, 1'b0);   // step 2
    checkOutput("s2 a.PCWrite", {31'd0, a_pcw}, 32'd1);
    checkOutput("s2 b.PCWrite", {31'd0, b_pcw}, 32'd0);
    checkOutput("s2 a.Instruction_out held", a_instr, I1);
    applyStimulus(I2, 32'd8, 1'b0, 5'd0, 1'b0);   // step 3
    checkOutput("s3 a.Instruction_out", a_instr, I2);
    checkOutput("s3 b.PCWrite", {31'd0, b_pcw}, 32'd0);
    checkOutput("s3 b.Instruction_out held", b_instr, I1);
    applyStimulus(I2, 32'd8, 1'b0, 5'd0, 1'b0);   // step 4
    checkOutput("s4 b.PCWrite", {31'd0, b_pcw}, 32'd1);
    applyStimulus(I3, 32'd12, 1'b0, 5'd0, 1'b0);  // step 5
    checkOutput("s5 b.Instruction_out", b_instr, I2);
    applyStimulus(I4, 32'd16, 1'b0, 5'd0, 1'b0);  // step 6
    applyStimulus(I5, 32'd20, 1'b1, 5'd0, 1'b0);  // step 7: load to $0
    checkOutput("s7 a.PCWrite rt0", {31'd0, a_pcw}, 32'd1);
    checkOutput("s7 b.Bubble rt0", {31'd0, b_bub}, 32'd0);
    applyStimulus(I6, 32'd24, 1'b0, 5'd0, 1'b1);  // step 8: flush
    checkOutput("s8 a.Bubble", {31'd0, a_bub}, 32'd1);
    applyStimulus(I6, 32'd24, 1'b1, 5'd5, 1'b0);  // step 9
    checkOutput("s9 a.Valid_out", {31'd0, a_valid}, 32'd0);
    checkOutput("s9 a.PCAdder_out", a_pc, 32'd24);
    checkOutput("s9 a.PCWrite invalid", {31'd0, a_pcw}, 32'd1);
    checkOutput("s9 b.Bubble", {31'd0, b_bub}, 32'd0);
    applyStimulus(I7, 32'd28, 1'b0, 5'd0, 1'b0);  // step 10
    checkOutput("s10 b.Valid_out", {31'd0, b_valid}, 32'd0);
    checkOutput("s10 a.Valid_out", {31'd0, a_valid}, 32'd1);
    applyStimulus(I8, 32'd32, 1'b1, 5'd11, 1'b1); // step 11: hazard + flush
    checkOutput("s11 a.PCWrite", {31'd0, a_pcw}, 32'd1);
    checkOutput("s11 a.Bubble", {31'd0, a_bub}, 32'd1);
    applyStimulus(I8, 32'd32, 1'b0, 5'd0, 1'b0);  // step 12
    checkOutput("s12 a.Instruction_out", a_instr, 32'h0);
    checkOutput("s12 a.PCAdder_out", a_pc, 32'd32);
    applyStimulus(I1, 32'd36, 1'b0, 5'd0, 1'b0);  // step 13
    applyStimulus(I10, 32'd40, 1'b1, 5'd8, 1'b0); // step 14: rt match
    checkOutput("s14 b.PCWrite", {31'd0, b_pcw}, 32'd0);
    applyStimulus(I10, 32'd40, 1'b0, 5'd0, 1'b1); // step 15: flush in STALL
    checkOutput("s15 b.PCWrite", {31'd0, b_pcw}, 32'd1);
    checkOutput("s15 b.Bubble", {31'd0, b_bub}, 32'd1);
    applyStimulus(I10, 32'd40, 1'b0, 5'd0, 1'b0); // step 16
    applyStimulus(I10, 32'd40, 1'b0, 5'd0, 1'b0); // step 17
    checkOutput("s17 b.Valid_out", {31'd0, b_valid}, 32'd0);
    checkOutput("s17 a.Instruction_out", a_instr, I10);
`ifdef IF_ID_PERF_CNT_EN
    checkOutput("perf a.StallCount", a_stall_cnt, 32'd2);
    checkOutput("perf b.StallCount", b_stall_cnt, 32'd4);
    checkOutput("perf b.FlushCount", b_flush_cnt, 32'd3);
`endif
    applyStimulus(LW, 32'd44, 1'b0, 5'd0, 1'b0);  // step 18
    applyStimulus(LW, 32'd44, 1'b0, 5'd0, 1'b0);  // step 19
    checkOutput("pre-reset a.Instruction_out", a_instr, LW);
    #1 Rst = 1'b0;
    #1;
    checkOutput("async a.Instruction_out", a_instr, 32'h0);
    checkOutput("async b.PCAdder_out", b_pc, 32'h0);
    checkOutput("async a.Valid_out", {31'd0, a_valid}, 32'd0);
    checkOutput("async a.PCWrite", {31'd0, a_pcw}, 32'd1);
    checkOutput("async b.Bubble", {31'd0, b_bub}, 32'd0);
    @(negedge Clk);
    #1 Rst = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_stage.md
Name: if_id_hazard_stage

Overview:
- IF/ID pipeline register with integrated load-use hazard detection and branch/jump flush control.
- Sits between the fetch stage (PC adder, instruction memory) and decode; its outputs feed the register file, the control unit and the ID/EX register.
- Generates PC-write enable, IF/ID hold, and an ID/EX control-bubble request.

Parameters:
- LOAD_STALL_CYCLES, 1, cycles IF/ID and PC are frozen per detected load-use hazard (1..7).
- FLUSH_DEPTH, 1, fetch slots squashed per taken branch/jump (1..3; 1 = squash only the slot arriving this cycle).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Instruction_in  in  32  fetched instruction.
- PCAdder_in  in  32  PC+4 of fetched instruction.
- MemRead_EX  in  1  MemRead_out of ID/EX register.
- AddressRt_EX  in  5  destination (rt) of instruction in EX.
- Flush_in  in  1  taken branch or JRegControl/jump resolved this cycle.
- Instruction_out  out  32  registered instruction to decode.
- PCAdder_out  out  32  registered PC+4.
- Valid_out  out  1  Instruction_out is a real instruction (0 = squashed NOP).
- PCWrite  out  1  PC register enable.
- Bubble  out  1  zero all control inputs of ID/EX this cycle.

Behaviour:
- Reset (Rst=0, async): Instruction_out=0, PCAdder_out=0, Valid_out=0, FSM=RUN, counters=0. Combinational outputs then read PCWrite=1, Bubble=0.
- Hazard (combinational): rs=Instruction_out[25:21], rt=Instruction_out[20:16]. Hazard = Valid_out & MemRead_EX & (AddressRt_EX!=0) & (AddressRt_EX==rs | AddressRt_EX==rt).
- FSM has three states: RUN, STALL, FLUSH.
- RUN, no hazard, no flush:
  - Register loads Instruction_in and PCAdder_in; Valid_out<=1.
  - PCWrite=1, Bubble=0.
- RUN with hazard and no flush:
  - Hold register; PCWrite=0, Bubble=1.
  - If LOAD_STALL_CYCLES>1, go to STALL with stall_cnt<=LOAD_STALL_CYCLES-1; else stay in RUN.
- STALL:
  - Hold register; PCWrite=0, Bubble=1.
  - stall_cnt decrements each cycle; at 1 go to RUN.
  - Hazard is not re-evaluated while in STALL.
- Flush_in=1 (any state; highest priority):
  - Register loads Instruction_out<=0, Valid_out<=0; PCAdder_out still loads PCAdder_in.
  - PCWrite=1, Bubble=1.
  - If FLUSH_DEPTH>1, go to FLUSH with flush_cnt<=FLUSH_DEPTH-1; else go to RUN.
  - Any stall in progress is abandoned.
- FLUSH:
  - Each cycle loads NOP with Valid_out=0; PCWrite=1, Bubble=0.
  - flush_cnt decrements; at 1 go to RUN.
  - A new Flush_in reloads flush_cnt.
- Latency: one cycle, Instruction_in to Instruction_out.
- A held instruction is never lost or duplicated.
- Valid_out=0 instructions never raise Hazard.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCount[31:0] and FlushCount[31:0], both reset to 0 by Rst.
  - StallCount increments on every cycle with PCWrite=0.
  - FlushCount increments on every cycle with Flush_in=1.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state encoding: RUN=2'd0, STALL=2'd1, FLUSH=2'd2.
  - NOP_INSTR=32'h0.
  - Field slice constants RS_MSB/LSB=25/21 and RT_MSB/LSB=20/16.
- One natural sub-module: load_use_detect, the purely combinational hazard compare, reused later by forwarding logic.

Test Plan:
- Reset: hold Rst=0 mid-run with Instruction_in=32'h8C090004 → all registered outputs 0 immediately (async), PCWrite=1, Bubble=0.
- Load-use stall, rs match: ID holds add $10,$9,$8 (32'h01285020), EX has MemRead_EX=1, AddressRt_EX=9 → one cycle PCWrite=0, Bubble=1, Instruction_out held; next cycle (MemRead_EX=0) loads the new instruction.
- No hazard on $0 or on an invalid slot: AddressRt_EX=0, or Valid_out=0 with a matching rt → PCWrite stays 1.
- Flush overrides stall: hazard and Flush_in asserted together → Instruction_out=0, Valid_out=0, PCWrite=1, FSM=RUN.
- Multi-cycle parameters: LOAD_STALL_CYCLES=3 → PCWrite low exactly 3 cycles. FLUSH_DEPTH=2 → 2 consecutive Valid_out=0 slots.
- With IF_ID_PERF_CNT_EN, after the two stall scenarios (1+3 stalled cycles) → StallCount=4; after 2 flush pulses → FlushCount=2.
